// File: rtl/swipt_link_scheduler.sv
// SWIPT link scheduler: listens for a 36-bit frame, verifies its ones-count checksum,
// hands the link to the response transmitter and holds a receiver-flush guard gap.
module swipt_link_scheduler #(
  parameter int FRAME_BITS     = 36,
  parameter int BIT_TIMEOUT    = 400000,
  parameter int LISTEN_TIMEOUT = 1000000,
  parameter int GUARD_CYCLES   = 1000,
  parameter int CNT_W          = 21
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  swiptAlive,
  input  logic [1:0]            prog,
  input  logic                  bitStrobe,
  input  logic                  rxBit,
  input  logic                  txAck,
  input  logic                  txDone,
  output logic                  readDataIn,
  output logic                  frameValid,
  output logic [FRAME_BITS-1:0] frame,
  output logic [1:0]            rxMode,
  output logic [1:0]            rxType,
  output logic                  txReq,
  output logic [1:0]            txCode,
  output logic                  errTimeout,
  output logic                  errChecksum,
  output logic                  busy
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LISTEN    = 3'd1;
  localparam logic [2:0] S_RECEIVE   = 3'd2;
  localparam logic [2:0] S_CHECK     = 3'd3;
  localparam logic [2:0] S_RESPOND   = 3'd4;
  localparam logic [2:0] S_WAIT_DONE = 3'd5;
  localparam logic [2:0] S_GUARD     = 3'd6;

  localparam int SUM_BITS = FRAME_BITS - 8;
  localparam int BC_W     = $clog2(FRAME_BITS + 1);

  logic [2:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic [BC_W-1:0]       bitCnt;
  logic [7:0]            ones;
  logic [FRAME_BITS-1:0] shreg;
  logic [FRAME_BITS-1:0] shNext;
  logic                  gateOpen;

  // ANSWER only for mode 00 queries of type 01/10; everything else is confirmed.
  function automatic logic [1:0] resp_code(input logic [1:0] mode, input logic [1:0] typ);
    if (mode == 2'b00 && (typ == 2'b01 || typ == 2'b10)) return 2'b10;
    return 2'b01;
  endfunction

  assign gateOpen   = swiptAlive && (prog == 2'b11);
  assign shNext     = {shreg[FRAME_BITS-2:0], rxBit};
  assign readDataIn = (state == S_LISTEN) || (state == S_RECEIVE);
  assign busy       = !((state == S_IDLE) || (state == S_LISTEN));

  always_ff @(posedge clk) begin
    if (rst || !gateOpen) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bitCnt      <= '0;
      ones        <= '0;
      shreg       <= '0;
      frame       <= '0;
      rxMode      <= '0;
      rxType      <= '0;
      txReq       <= 1'b0;
      txCode      <= '0;
      frameValid  <= 1'b0;
      errTimeout  <= 1'b0;
      errChecksum <= 1'b0;
    end else begin
      frameValid  <= 1'b0;
      errTimeout  <= 1'b0;
      errChecksum <= 1'b0;
      case (state)
        S_IDLE: begin
          state  <= S_LISTEN;
          cnt    <= '0;
          bitCnt <= '0;
          ones   <= '0;
        end
        S_LISTEN: begin
          if (bitStrobe) begin
            shreg  <= shNext;
            bitCnt <= BC_W'(1);
            ones   <= {7'd0, rxBit};
            cnt    <= '0;
            state  <= S_RECEIVE;
          end else if (cnt == CNT_W'(LISTEN_TIMEOUT - 1)) begin
            errTimeout <= 1'b1;
            cnt        <= '0;
            state      <= S_GUARD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_RECEIVE: begin
          if (bitStrobe) begin
            shreg  <= shNext;
            bitCnt <= bitCnt + BC_W'(1);
            cnt    <= '0;
            if (bitCnt < BC_W'(SUM_BITS)) ones <= ones + {7'd0, rxBit};
            // Final bit lies in the checksum byte, so ones is already complete here.
            if (bitCnt == BC_W'(FRAME_BITS - 1)) begin
              state      <= S_CHECK;
              frameValid <= 1'b1;
              frame      <= shNext;
              rxMode     <= shNext[FRAME_BITS-1 -: 2];
              rxType     <= shNext[FRAME_BITS-3 -: 2];
              if (ones == shNext[7:0]) begin
                txCode <= resp_code(shNext[FRAME_BITS-1 -: 2], shNext[FRAME_BITS-3 -: 2]);
              end else begin
                errChecksum <= 1'b1;
                txCode      <= 2'b11;
              end
            end
          end else if (cnt == CNT_W'(BIT_TIMEOUT - 1)) begin
            errTimeout <= 1'b1;
            cnt        <= '0;
            state      <= S_GUARD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_CHECK: begin
          txReq <= 1'b1;
          state <= S_RESPOND;
        end
        S_RESPOND: begin
          if (txAck) begin
            txReq <= 1'b0;
            cnt   <= '0;
            state <= txDone ? S_GUARD : S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (txDone) begin
            cnt   <= '0;
            state <= S_GUARD;
          end
        end
        S_GUARD: begin
          if (cnt == CNT_W'(GUARD_CYCLES - 1)) begin
            cnt    <= '0;
            bitCnt <= '0;
            ones   <= '0;
            state  <= S_LISTEN;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_swipt_link_scheduler.sv
// Bench for swipt_link_scheduler: table-driven frames, directed timeout/gate/reset
// sequences and randomized frames checked against a checksum/response model.
module tb_swipt_link_scheduler;

  logic        clk;
  logic        rst;
  logic        swiptAlive;
  logic [1:0]  prog;
  logic        bitStrobe;
  logic        rxBit;
  logic        txAck;
  logic        txDone;
  logic        readDataIn;
  logic        frameValid;
  logic [35:0] frame;
  logic [1:0]  rxMode;
  logic [1:0]  rxType;
  logic        txReq;
  logic [1:0]  txCode;
  logic        errTimeout;
  logic        errChecksum;
  logic        busy;

  int total = 0;
  int bad   = 0;

  swipt_link_scheduler #(
    .BIT_TIMEOUT(50), .LISTEN_TIMEOUT(200), .GUARD_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .swiptAlive(swiptAlive), .prog(prog),
    .bitStrobe(bitStrobe), .rxBit(rxBit), .txAck(txAck), .txDone(txDone),
    .readDataIn(readDataIn), .frameValid(frameValid), .frame(frame),
    .rxMode(rxMode), .rxType(rxType), .txReq(txReq), .txCode(txCode),
    .errTimeout(errTimeout), .errChecksum(errChecksum), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  typedef struct {
    logic [35:0] f;
    int          gap;
    int          ackdly;
    logic [1:0]  code;
    logic        err;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Response expected from the frame alone: checksum is the popcount of the 28 header/payload bits.
  function automatic logic [2:0] ref_resp(input logic [35:0] f);
    int n;
    n = $countones(f[35:8]) % 256;
    if (n != int'(f[7:0])) return 3'b111;
    if (f[35:34] == 2'b00 && (f[33:32] == 2'b01 || f[33:32] == 2'b10)) return 3'b010;
    return 3'b001;
  endfunction

  task automatic send_bits(input logic [35:0] f, input int nbits, input int gap);
    for (int i = 0; i < nbits; i++) begin
      bitStrobe = 1'b1;
      rxBit     = f[35-i];
      @(negedge clk);
      bitStrobe = 1'b0;
      rxBit     = 1'b0;
      if (i < nbits - 1) repeat (gap) @(negedge clk);
    end
  endtask

  task automatic guard_len(output int n, output int etc);
    n   = 0;
    etc = 0;
    while (!readDataIn && n < 20) begin
      n++;
      if (errTimeout) etc++;
      bitStrobe = (n == 2);
      @(negedge clk);
    end
    bitStrobe = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [35:0] f, input int gap,
                           input int ackdly, input int donedly,
                           input logic [1:0] code, input logic err);
    int n, etc;
    n = 0;
    while (!(readDataIn && !busy) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_listen"}, {63'd0, readDataIn}, 64'd1);
    send_bits(f, 36, gap);
    check({tag, "_fv"}, {63'd0, frameValid}, 64'd1);
    check({tag, "_frame"}, {28'd0, frame}, {28'd0, f});
    check({tag, "_mode"}, {62'd0, rxMode}, {62'd0, f[35:34]});
    check({tag, "_type"}, {62'd0, rxType}, {62'd0, f[33:32]});
    check({tag, "_errcs"}, {63'd0, errChecksum}, {63'd0, err});
    check({tag, "_code"}, {62'd0, txCode}, {62'd0, code});
    @(negedge clk);
    check({tag, "_fv_pulse"}, {62'd0, frameValid, errChecksum}, 64'd0);
    check({tag, "_txreq"}, {63'd0, txReq}, 64'd1);
    repeat (ackdly) @(negedge clk);
    check({tag, "_txreq_hold"}, {61'd0, txReq, txCode}, {61'd0, 1'b1, code});
    txAck = 1'b1;
    @(negedge clk);
    txAck = 1'b0;
    check({tag, "_txreq_drop"}, {62'd0, txReq, busy}, 64'd1);
    repeat (donedly) @(negedge clk);
    txDone = 1'b1;
    @(negedge clk);
    txDone = 1'b0;
    guard_len(n, etc);
    check({tag, "_guard"}, 64'(n), 64'd4);
  endtask

  initial begin
    int n, etc, fvseen;
    logic [35:0] f;
    logic [2:0]  r;

    vecs[0] = '{36'h0_5A5A5A_0C, 0,  1, 2'b01, 1'b0};
    vecs[1] = '{36'h1_123456_0A, 1,  3, 2'b10, 1'b0};
    vecs[2] = '{36'h0_5A5A5A_0D, 0,  1, 2'b11, 1'b1};
    vecs[3] = '{36'h2_000000_01, 49, 0, 2'b10, 1'b0};
    vecs[4] = '{36'hF_FFFFFF_1C, 2,  2, 2'b01, 1'b0};
    vecs[5] = '{36'h3_000000_02, 0,  0, 2'b01, 1'b0};
    vecs[6] = '{36'h4_00000F_05, 3,  4, 2'b01, 1'b0};

    rst = 1'b1; swiptAlive = 1'b1; prog = 2'b11;
    bitStrobe = 1'b0; rxBit = 1'b0; txAck = 1'b0; txDone = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {24'd0, readDataIn, frameValid, rxMode, rxType, txReq, txCode,
          errTimeout, errChecksum, busy}, 64'd0);
    check("reset_frame", {28'd0, frame}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("listen_after_reset", {62'd0, readDataIn, busy}, 64'd2);

    // Listen timeout, measured from the first LISTEN cycle.
    n = 0;
    while (!errTimeout && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("listen_timeout_cycles", 64'(n), 64'd200);
    check("listen_timeout_rdi", {63'd0, readDataIn}, 64'd0);
    guard_len(n, etc);
    check("listen_timeout_guard", 64'(n), 64'd4);
    check("listen_timeout_pulse", 64'(etc), 64'd1);

    for (int i = 0; i < 7; i++)
      run_frame($sformatf("vec%0d", i), vecs[i].f, vecs[i].gap, vecs[i].ackdly, 1,
                vecs[i].code, vecs[i].err);

    // Inter-bit timeout after 10 bits.
    send_bits(36'h0_5A5A5A_0C, 10, 0);
    n = 0; fvseen = 0;
    while (!errTimeout && n < 100) begin
      @(negedge clk);
      n++;
      if (frameValid) fvseen++;
    end
    check("bit_timeout_cycles", 64'(n), 64'd50);
    check("bit_timeout_no_fv", 64'(fvseen), 64'd0);
    guard_len(n, etc);
    check("bit_timeout_guard", 64'(n), 64'd4);

    // Program leaves 2'b11 mid-frame.
    send_bits(36'h0_5A5A5A_0C, 10, 0);
    prog = 2'b01;
    @(negedge clk);
    check("gate_outputs", {61'd0, readDataIn, busy, txReq}, 64'd0);
    check("gate_frame", {28'd0, frame}, 64'd0);
    repeat (3) @(negedge clk);
    prog = 2'b11;
    @(negedge clk);
    check("gate_relisten", {62'd0, readDataIn, busy}, 64'd2);

    // Reset while requesting the link.
    send_bits(36'h0_5A5A5A_0C, 36, 0);
    @(negedge clk);
    check("rst_resp_txreq", {63'd0, txReq}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_resp_drop", {62'd0, txReq, readDataIn}, 64'd0);
    check("rst_resp_frame", {28'd0, frame}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_resp_listen", {62'd0, readDataIn, busy}, 64'd2);

    // txAck and txDone together skip WAIT_DONE.
    send_bits(36'h1_123456_0A, 36, 0);
    @(negedge clk);
    txAck = 1'b1; txDone = 1'b1;
    @(negedge clk);
    txAck = 1'b0; txDone = 1'b0;
    check("ackdone_txreq", {63'd0, txReq}, 64'd0);
    guard_len(n, etc);
    check("ackdone_guard", 64'(n), 64'd4);

    for (int i = 0; i < 10; i++) begin
      f[35:8] = 28'($urandom);
      if ($urandom_range(0, 2) == 0) f[35:34] = 2'b00;
      if ($urandom_range(0, 1) == 1) f[7:0] = 8'($countones(f[35:8]));
      else f[7:0] = 8'($urandom);
      r = ref_resp(f);
      run_frame($sformatf("rnd%0d", i), f, int'($urandom_range(0, 3)),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), r[1:0], r[2]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
